// File: rtl/branch_pkg.sv
// branch_pkg: branch opcodes, BHT counter encodings and the shared compare function.
package branch_pkg;

    typedef enum logic [4:0] {
        BR_EQ   = 5'b00000,
        BR_NE   = 5'b00001,
        BR_LT   = 5'b00100,
        BR_GE   = 5'b00101,
        BR_LTU  = 5'b00110,
        BR_GEU  = 5'b00111,
        BR_JAL  = 5'b01000,
        BR_JALR = 5'b10111
    } brop_e;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Operands arrive sign-extended to 64 bits; that preserves both signed and
    // unsigned ordering, so one function serves any XLEN up to 64.
    function automatic logic br_eval(input logic [4:0] brop, input logic [63:0] rs1, input logic [63:0] rs2);
        logic eq, lt, ltu, r;
        eq  = rs1 == rs2;
        lt  = $signed(rs1) < $signed(rs2);
        ltu = rs1 < rs2;
        casez (brop)
            BR_EQ:    r = eq;
            BR_NE:    r = ~eq;
            BR_LT:    r = lt;
            BR_GE:    r = ~lt;
            BR_LTU:   r = ltu;
            BR_GEU:   r = ~ltu;
            5'b01???: r = 1'b1;
            BR_JALR:  r = 1'b1;
            default:  r = 1'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/branch_resolve_unit_bht_table.sv
// bht_table: array of 2-bit saturating counters, combinational read, one update port.
module bht_table
    import branch_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] rd_pc_i,
    output logic            rd_taken_o,
    input  logic            upd_en_i,
    input  logic [XLEN-1:0] upd_pc_i,
    input  logic            upd_taken_i
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       ctr_q [BHT_ENTRIES];
    logic [1:0]       ctr_d;
    logic [1:0]       upd_ctr;
    logic [IDX_W-1:0] rd_idx, upd_idx;
    logic             unused_pc;

    // Instruction alignment makes pc[1:0] meaningless; upper bits alias.
    assign unused_pc  = ^{rd_pc_i[1:0], rd_pc_i[XLEN-1:IDX_W+2], upd_pc_i[1:0], upd_pc_i[XLEN-1:IDX_W+2]};
    assign rd_idx     = rd_pc_i[IDX_W+1:2];
    assign upd_idx    = upd_pc_i[IDX_W+1:2];
    assign rd_taken_o = ctr_q[rd_idx][1];

    always_comb begin
        upd_ctr = ctr_q[upd_idx];
        ctr_d   = upd_taken_i ? (upd_ctr == CTR_ST  ? CTR_ST  : upd_ctr + 2'd1)
                              : (upd_ctr == CTR_SNT ? CTR_SNT : upd_ctr - 2'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) ctr_q[i] <= CTR_WNT;
        end else if (upd_en_i) begin
            ctr_q[upd_idx] <= ctr_d;
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: registered branch/jump resolution with a 2-bit BHT predictor.
// Optional performance counters enabled by defining BRANCH_PERF_CNT_EN.
module branch_resolve_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int BHT_ENTRIES = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] fetch_pc_i,
    output logic            pred_taken_o,
    input  logic            res_valid_i,
    input  logic [XLEN-1:0] res_pc_i,
    input  logic [4:0]      brop_i,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic            pred_taken_i,
    input  logic            flush_i,
    output logic            out_valid_o,
    output logic            taken_o,
    output logic            mispredict_o,
    output logic [31:0]     branch_cnt_o,
    output logic [31:0]     mispred_cnt_o
);

    logic res_taken, accept, bht_upd;
    logic out_valid_d, taken_d, mispredict_d;
    logic out_valid_q, taken_q, mispredict_q;

    always_comb begin
        res_taken    = br_eval(brop_i, 64'($signed(rs1_i)), 64'($signed(rs2_i)));
        accept       = res_valid_i & ~flush_i;
        bht_upd      = accept & (brop_i[4:3] == 2'b00);
        out_valid_d  = accept;
        taken_d      = res_valid_i ? res_taken : taken_q;
        mispredict_d = accept & (res_taken != pred_taken_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            taken_q      <= 1'b0;
            mispredict_q <= 1'b0;
        end else begin
            out_valid_q  <= out_valid_d;
            taken_q      <= taken_d;
            mispredict_q <= mispredict_d;
        end
    end

    assign out_valid_o  = out_valid_q;
    assign taken_o      = taken_q;
    assign mispredict_o = mispredict_q;

    bht_table #(
        .BHT_ENTRIES(BHT_ENTRIES),
        .XLEN       (XLEN)
    ) u_bht (
        .clk        (clk),
        .rst        (rst),
        .rd_pc_i    (fetch_pc_i),
        .rd_taken_o (pred_taken_o),
        .upd_en_i   (bht_upd),
        .upd_pc_i   (res_pc_i),
        .upd_taken_i(res_taken)
    );

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] branch_cnt_q, branch_cnt_d, mispred_cnt_q, mispred_cnt_d;

    always_comb begin
        branch_cnt_d  = (bht_upd && branch_cnt_q != '1) ? branch_cnt_q + 32'd1 : branch_cnt_q;
        mispred_cnt_d = (mispredict_d && mispred_cnt_q != '1) ? mispred_cnt_q + 32'd1 : mispred_cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt_o  = branch_cnt_q;
    assign mispred_cnt_o = mispred_cnt_q;
`else
    assign branch_cnt_o  = '0;
    assign mispred_cnt_o = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// tb_branch_resolve_unit: scoreboard bench with an independent BHT and compare model.
module tb_branch_resolve_unit;

`ifdef BRANCH_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    typedef struct packed {
        logic valid;
        logic taken;
        logic misp;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetch_pc_i = 32'h40;
    logic        pred_taken_o;
    logic        res_valid_i = 1'b0;
    logic [31:0] res_pc_i = '0;
    logic [4:0]  brop_i = '0;
    logic [31:0] rs1_i = '0;
    logic [31:0] rs2_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        flush_i = 1'b0;
    logic        out_valid_o, taken_o, mispredict_o;
    logic [31:0] branch_cnt_o, mispred_cnt_o;

    int          total = 0;
    int          bad = 0;
    exp_t        sb[$];
    logic [1:0]  m_ctr [64];
    logic        m_taken;
    logic [31:0] m_bcnt, m_mcnt;

    branch_resolve_unit dut (
        .clk          (clk),
        .rst          (rst),
        .fetch_pc_i   (fetch_pc_i),
        .pred_taken_o (pred_taken_o),
        .res_valid_i  (res_valid_i),
        .res_pc_i     (res_pc_i),
        .brop_i       (brop_i),
        .rs1_i        (rs1_i),
        .rs2_i        (rs2_i),
        .pred_taken_i (pred_taken_i),
        .flush_i      (flush_i),
        .out_valid_o  (out_valid_o),
        .taken_o      (taken_o),
        .mispredict_o (mispredict_o),
        .branch_cnt_o (branch_cnt_o),
        .mispred_cnt_o(mispred_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic model_eval(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            5'd0:    return a == b;
            5'd1:    return a != b;
            5'd4:    return $signed(a) < $signed(b);
            5'd5:    return $signed(a) >= $signed(b);
            5'd6:    return a < b;
            5'd7:    return a >= b;
            5'd23:   return 1'b1;
            default: return op[4:3] == 2'b01;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) m_ctr[i] = 2'b01;
        m_taken = 1'b0;
        m_bcnt  = '0;
        m_mcnt  = '0;
        sb.delete();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_valid"}, 32'(out_valid_o), 32'd0);
        chk({tag, "_taken"}, 32'(taken_o), 32'd0);
        chk({tag, "_misp"}, 32'(mispredict_o), 32'd0);
        chk({tag, "_pred"}, 32'(pred_taken_o), 32'(m_ctr[fetch_pc_i[7:2]][1]));
        chk({tag, "_bcnt"}, branch_cnt_o, 32'd0);
        chk({tag, "_mcnt"}, mispred_cnt_o, 32'd0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        res_valid_i = 1'b0;
        flush_i = 1'b0;
        #1 model_reset();
        check_idle("rst");
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One cycle: drive at negedge, check pre-update prediction, push expectation,
    // then pop and compare the registered result just after the posedge.
    task automatic step(input string tag, input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic pred, input logic fl, input logic v,
                        input logic [31:0] fpc);
        exp_t e, got;
        logic r;
        @(negedge clk);
        res_valid_i = v; brop_i = op; rs1_i = a; rs2_i = b; res_pc_i = pc;
        pred_taken_i = pred; flush_i = fl; fetch_pc_i = fpc;
        #1 chk({tag, "_pred"}, 32'(pred_taken_o), 32'(m_ctr[fpc[7:2]][1]));
        r = model_eval(op, a, b);
        e.valid = v & ~fl;
        e.taken = v ? r : m_taken;
        e.misp  = v & ~fl & (r != pred);
        m_taken = e.taken;
        sb.push_back(e);
        if (v && !fl && op[4:3] == 2'b00) begin
            m_ctr[pc[7:2]] = r ? (m_ctr[pc[7:2]] == 2'b11 ? 2'b11 : m_ctr[pc[7:2]] + 2'd1)
                               : (m_ctr[pc[7:2]] == 2'b00 ? 2'b00 : m_ctr[pc[7:2]] - 2'd1);
            m_bcnt++;
        end
        if (e.misp) m_mcnt++;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            chk({tag, "_valid"}, 32'(out_valid_o), 32'(got.valid));
            chk({tag, "_taken"}, 32'(taken_o), 32'(got.taken));
            chk({tag, "_misp"}, 32'(mispredict_o), 32'(got.misp));
        end
        chk({tag, "_bcnt"}, branch_cnt_o, PERF ? m_bcnt : 32'd0);
        chk({tag, "_mcnt"}, mispred_cnt_o, PERF ? m_mcnt : 32'd0);
    endtask

    initial begin
        model_reset();
        #1 check_idle("init");
        do_reset();

        step("blt",  5'b00100, 32'hFFFF_FFFF, 32'd1, 32'h44, 1'b0, 1'b0, 1'b1, 32'h44);
        step("bltu", 5'b00110, 32'hFFFF_FFFF, 32'd1, 32'h48, 1'b0, 1'b0, 1'b1, 32'h48);
        step("bge",  5'b00101, 32'h8000_0000, 32'h7FFF_FFFF, 32'h4C, 1'b1, 1'b0, 1'b1, 32'h44);
        step("bgeu", 5'b00111, 32'h8000_0000, 32'h7FFF_FFFF, 32'h50, 1'b1, 1'b0, 1'b1, 32'h48);
        step("idle", 5'b00000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h4C);

        for (int i = 0; i < 8; i++)
            step("beq_t", 5'b00000, 32'd9, 32'd9, 32'h100, 1'b0, 1'b0, 1'b1, 32'h100);
        for (int i = 0; i < 3; i++)
            step("beq_n", 5'b00000, 32'd9, 32'd8, 32'h100, 1'b1, 1'b0, 1'b1, 32'h100);
        step("beq_chk", 5'b00000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h100);

        do_reset();
        step("same",  5'b00000, 32'd5, 32'd5, 32'h200, 1'b0, 1'b0, 1'b1, 32'h200);
        step("after", 5'b00000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h200);

        step("jal",   5'b01111, 32'd1, 32'd2, 32'h0, 1'b0, 1'b0, 1'b1, 32'h0);
        step("jalr",  5'b10111, 32'd1, 32'd2, 32'h8, 1'b1, 1'b0, 1'b1, 32'h0);
        step("inv",   5'b10101, 32'd1, 32'd1, 32'h10, 1'b1, 1'b0, 1'b1, 32'h10);
        step("flush", 5'b00001, 32'd3, 32'd4, 32'h304, 1'b0, 1'b1, 1'b1, 32'h304);
        step("flchk", 5'b00000, 32'd0, 32'd0, 32'h0, 1'b0, 1'b0, 1'b0, 32'h304);

        for (int i = 0; i < 6; i++)
            step("rnd", 5'($urandom_range(0, 7)), $urandom, $urandom, 32'(i * 4), 1'($urandom_range(0, 1)),
                 1'b0, 1'b1, 32'(i * 4));

        // Mid-cycle async reset loses the in-flight result immediately.
        @(negedge clk);
        res_valid_i = 1'b1; brop_i = 5'b00000; rs1_i = 32'd1; rs2_i = 32'd1; res_pc_i = 32'h40;
        pred_taken_i = 1'b0; flush_i = 1'b0; fetch_pc_i = 32'h40;
        @(posedge clk);
        #2 rst = 1'b1;
        #1 model_reset();
        check_idle("async");
        @(negedge clk);
        rst = 1'b0;
        res_valid_i = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_resolve_unit.md
Name: branch_resolve_unit

Overview:
- Parametrised successor to the single-cycle branch comparator.
- Resolves conditional branches and jumps with correct signed/unsigned RISC-V compare semantics (rs1 op rs2).
- Registers the outcome with 1-cycle latency.
- Owns a 2-bit saturating branch history table (BHT) that serves fetch-stage predictions and flags mispredictions back to the PC logic.

Parameters:
- XLEN, 32: operand and PC width.
- BHT_ENTRIES, 64: number of 2-bit counters; must be a power of 2, ≥2.
- BHT_IDX_W, $clog2(BHT_ENTRIES): index width, derived; not overridden.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-high.
- fetch_pc_i  in  XLEN  fetch-stage PC used for BHT lookup.
- pred_taken_o  out  1  combinational BHT prediction for fetch_pc_i.
- res_valid_i  in  1  a branch/jump is presented for resolution this cycle.
- res_pc_i  in  XLEN  PC of the instruction being resolved.
- brop_i  in  5  branch opcode.
- rs1_i  in  XLEN  first register operand.
- rs2_i  in  XLEN  second register operand.
- pred_taken_i  in  1  prediction fetch made for this instruction.
- flush_i  in  1  squash the instruction in the output register.
- out_valid_o  out  1  registered: resolution result valid.
- taken_o  out  1  registered resolved direction (NextPCSrc equivalent).
- mispredict_o  out  1  registered: taken_o != recorded prediction.
- branch_cnt_o  out  32  resolved conditional-branch count (optional feature).
- mispred_cnt_o  out  32  misprediction count (optional feature).

Behaviour:
- Reset (async, rst=1):
  - out_valid_o, taken_o and mispredict_o go to 0.
  - All BHT counters go to 2'b01 (weakly not-taken).
  - Performance counters go to 0.
- BHT index: pc[BHT_IDX_W+1:2]; bits [1:0] are ignored.
- pred_taken_o = counter[idx(fetch_pc_i)][1]; purely combinational.
- brop_i decode, evaluated combinationally on the input side:
  - 00000 BEQ: rs1==rs2.
  - 00001 BNE: rs1!=rs2.
  - 00100 BLT: $signed(rs1)<$signed(rs2).
  - 00101 BGE: signed ≥.
  - 00110 BLTU: unsigned <.
  - 00111 BGEU: unsigned ≥.
  - 01xxx JAL: always taken.
  - 10111 JALR: always taken.
  - Every other code: not taken, not a branch. No latch; default arm required.
- Output register, at posedge:
  - out_valid_o <= res_valid_i.
  - taken_o <= decoded result.
  - mispredict_o <= res_valid_i & (result != pred_taken_i).
  - When res_valid_i=0: out_valid_o=0, mispredict_o=0; taken_o holds its previous value.
- flush_i=1 at a posedge forces out_valid_o and mispredict_o to 0 for that capture. flush_i has priority over res_valid_i, and the squashed instruction does not update the BHT.
- BHT update: only when res_valid_i & ~flush_i & brop_i[4:3]==2'b00 (conditional branches only); the counter at idx(res_pc_i) is updated at that posedge.
  - taken: increment, saturating at 2'b11.
  - not taken: decrement, saturating at 2'b00.
  - JAL/JALR never update the BHT.
- Same-index read and update in one cycle: pred_taken_o returns the pre-update value; no bypass.
- Mispredict covers all valid ops, including jumps predicted not-taken.
- Reset asserted mid-operation clears everything immediately; the in-flight result is lost.

Optional Feature:
- Macro: BRANCH_PERF_CNT_EN.
- Defined:
  - branch_cnt_o increments on each BHT update event.
  - mispred_cnt_o increments on each mispredict_o capture.
  - Both are 32-bit and saturate at 32'hFFFF_FFFF.
- Undefined: both ports are tied to 0 and no counter flops are generated. The port list is identical in both builds.

Decomposition:
- Package branch_pkg holds:
  - brop_e enum: BR_EQ, BR_NE, BR_LT, BR_GE, BR_LTU, BR_GEU, BR_JAL, BR_JALR.
  - Constants CTR_SNT=2'b00, CTR_WNT=2'b01, CTR_WT=2'b10, CTR_ST=2'b11.
  - Function br_eval(brop, rs1, rs2).
- Sub-module bht_table: counter array, async-reset init, combinational read port, one saturating update port. Parameters BHT_ENTRIES, XLEN.

Test Plan:
- Reset, then fetch_pc_i=0x40 -> pred_taken_o=0; branch_cnt_o=0 and mispred_cnt_o=0.
- BLT rs1=0xFFFF_FFFF, rs2=1, pred 0 -> next cycle taken_o=1, mispredict_o=1. Same operands with BLTU -> taken_o=0, mispredict_o=0.
- BEQ at pc=0x100 taken twice -> pred_taken_o for 0x100 becomes 1 after the first update (01→10). Six more taken updates keep the counter at 11; three not-taken updates give pred 0 (11→10→01→00).
- Same-cycle update and lookup of pc=0x200 with counter at 01, taken -> pred_taken_o=0 that cycle, 1 the next cycle.
- JAL brop=01111 with pred 0 -> taken_o=1, mispredict_o=1, BHT unchanged. Invalid brop=10101 -> taken_o=0.
- flush_i with a valid BNE (rs1=3, rs2=4) -> out_valid_o=0, mispredict_o=0, counter unchanged. With BRANCH_PERF_CNT_EN defined, counters are unchanged; without it, counters read 0 throughout.
